// File: rtl/facc_ctrl_if.sv
// Job, LLR-memory, F_Acc and result-stream signals of facc_ctrl.
// The slave modport is the controller; the master modport is its environment.
interface facc_ctrl_if #(
    parameter int bitwidth = 7,
    parameter int ADDR_W   = 8
);
    logic                    cmd_valid_i;
    logic                    cmd_ready_o;
    logic [ADDR_W-1:0]       base_addr_i;
    logic [3:0]              num_chunks_i;
    logic [31:0]             frozen_mask_i;
    logic                    llr_rd_en_o;
    logic [ADDR_W-1:0]       llr_rd_addr_o;
    logic [8*bitwidth-1:0]   llr_rd_data_i;
    logic [8*bitwidth-1:0]   facc_llr_o;
    logic [3:0]              facc_frozen_o;
    logic [3:0]              facc_bits_i;
    logic                    bits_valid_o;
    logic [3:0]              bits_o;
    logic [2:0]              bits_idx_o;
    logic                    busy_o;
    logic                    done_o;

    modport slave (
        input  cmd_valid_i, base_addr_i, num_chunks_i, frozen_mask_i,
        input  llr_rd_data_i, facc_bits_i,
        output cmd_ready_o, llr_rd_en_o, llr_rd_addr_o, facc_llr_o, facc_frozen_o,
        output bits_valid_o, bits_o, bits_idx_o, busy_o, done_o
    );

    modport master (
        output cmd_valid_i, base_addr_i, num_chunks_i, frozen_mask_i,
        output llr_rd_data_i, facc_bits_i,
        input  cmd_ready_o, llr_rd_en_o, llr_rd_addr_o, facc_llr_o, facc_frozen_o,
        input  bits_valid_o, bits_o, bits_idx_o, busy_o, done_o
    );
endinterface

// File: rtl/facc_ctrl.sv
// F_Acc job controller: issues up to 8 LLR chunk reads, tracks them through F_Acc, streams results.
// Optional macro FACC_CTRL_PERF_CNT_EN adds perf_cycles_o (handshake-to-done cycle count).
module facc_ctrl #(
    parameter int bitwidth = 7,
    parameter int ADDR_W   = 8,
    parameter int FACC_LAT = 3
) (
    input  logic         clk_i,
    input  logic         rst_i,
    facc_ctrl_if.slave   bus
`ifdef FACC_CTRL_PERF_CNT_EN
    ,
    output logic [15:0]  perf_cycles_o
`endif
);
    localparam int LLR_W = 8 * bitwidth;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [3:0]        n_q, n_d;
    logic [31:0]       mask_q, mask_d;
    logic [3:0]        k_q, k_d;
    logic [3:0]        frozen_q, frozen_d;
    logic              bits_vld_q, bits_vld_d;
    logic [3:0]        bits_q, bits_d;
    logic [2:0]        bits_idx_q, bits_idx_d;
    logic              vld_q [0:FACC_LAT];
    logic              vld_d [0:FACC_LAT];
    logic [2:0]        idx_q [0:FACC_LAT];
    logic [2:0]        idx_d [0:FACC_LAT];

    logic              issue;
    logic [3:0]        n_m1;
    logic [LLR_W-1:0]  llr_w;

    assign issue = (state_q == ISSUE);
    assign n_m1  = n_q - 4'd1;

    // Stage 0 holds the chunk whose LLRs are on the memory data bus this cycle.
    assign vld_d[0] = issue;
    assign idx_d[0] = k_q[2:0];

    genvar gi;
    generate
        for (gi = 1; gi <= FACC_LAT; gi++) begin : g_pipe_in
            assign vld_d[gi] = vld_q[gi-1];
            assign idx_d[gi] = idx_q[gi-1];
        end
        for (gi = 0; gi <= FACC_LAT; gi++) begin : g_pipe_reg
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    vld_q[gi] <= 1'b0;
                    idx_q[gi] <= 3'd0;
                end else begin
                    vld_q[gi] <= vld_d[gi];
                    idx_q[gi] <= idx_d[gi];
                end
            end
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        n_d        = n_q;
        mask_d     = mask_q;
        k_d        = k_q;
        frozen_d   = issue ? mask_q[{k_q[2:0], 2'b00} +: 4] : 4'hF;
        bits_vld_d = vld_q[FACC_LAT];
        bits_d     = vld_q[FACC_LAT] ? bus.facc_bits_i : 4'd0;
        bits_idx_d = vld_q[FACC_LAT] ? idx_q[FACC_LAT] : 3'd0;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid_i) begin
                    base_d  = bus.base_addr_i;
                    mask_d  = bus.frozen_mask_i;
                    n_d     = (bus.num_chunks_i > 4'd8) ? 4'd8 : bus.num_chunks_i;
                    k_d     = 4'd0;
                    state_d = (bus.num_chunks_i == 4'd0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                k_d = k_q + 4'd1;
                if (k_q == n_m1) state_d = DRAIN;
            end
            DRAIN: begin
                // Results leave in order, so the last index marks the end of the job.
                if (bits_vld_q && ({1'b0, bits_idx_q} == n_m1)) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            base_q     <= '0;
            n_q        <= 4'd0;
            mask_q     <= 32'd0;
            k_q        <= 4'd0;
            frozen_q   <= 4'hF;
            bits_vld_q <= 1'b0;
            bits_q     <= 4'd0;
            bits_idx_q <= 3'd0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            n_q        <= n_d;
            mask_q     <= mask_d;
            k_q        <= k_d;
            frozen_q   <= frozen_d;
            bits_vld_q <= bits_vld_d;
            bits_q     <= bits_d;
            bits_idx_q <= bits_idx_d;
        end
    end

    assign llr_w             = bus.llr_rd_data_i;
    assign bus.facc_llr_o    = llr_w;
    assign bus.facc_frozen_o = frozen_q;
    assign bus.llr_rd_en_o   = issue;
    assign bus.llr_rd_addr_o = issue ? (base_q + ADDR_W'(k_q)) : '0;
    assign bus.cmd_ready_o   = (state_q == IDLE);
    assign bus.busy_o        = (state_q == ISSUE) || (state_q == DRAIN);
    assign bus.done_o        = (state_q == DONE);
    assign bus.bits_valid_o  = bits_vld_q;
    assign bus.bits_o        = bits_q;
    assign bus.bits_idx_o    = bits_idx_q;

`ifdef FACC_CTRL_PERF_CNT_EN
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] perf_q, perf_d;

    // cnt_q already includes the handshake cycle; the done cycle is added on capture.
    always_comb begin
        cnt_d  = cnt_q;
        perf_d = perf_q;
        if (state_q == IDLE && bus.cmd_valid_i) begin
            cnt_d = 16'd1;
        end else if (state_q != IDLE && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
        if (state_q == DONE) begin
            perf_d = (cnt_q == 16'hFFFF) ? 16'hFFFF : cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= 16'd0;
            perf_q <= 16'd0;
        end else begin
            cnt_q  <= cnt_d;
            perf_q <= perf_d;
        end
    end

    assign perf_cycles_o = perf_q;
`endif
endmodule

// File: tb/tb_facc_ctrl.sv
// Directed bench for facc_ctrl: LLR memory and a 3-cycle F_Acc model, monitor queues, fixed jobs.
module tb_facc_ctrl;
    localparam int BW  = 7;
    localparam int AW  = 8;
    localparam int LAT = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    facc_ctrl_if #(.bitwidth(BW), .ADDR_W(AW)) bus ();

`ifdef FACC_CTRL_PERF_CNT_EN
    logic [15:0] perf;
`endif

    facc_ctrl #(.bitwidth(BW), .ADDR_W(AW), .FACC_LAT(LAT)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
`ifdef FACC_CTRL_PERF_CNT_EN
        ,
        .perf_cycles_o (perf)
`endif
    );

    // LLR memory (1-cycle read) whose low byte is addr^0xA5; F_Acc returns that low nibble 3 cycles later.
    logic [8*BW-1:0] rd_data = '0;
    logic [3:0] p1 = 4'd0, p2 = 4'd0, p3 = 4'd0;
    always @(posedge clk) begin
        if (bus.llr_rd_en_o) rd_data <= {48'h123456789ABC, bus.llr_rd_addr_o ^ 8'hA5};
        p1 <= bus.facc_llr_o[3:0];
        p2 <= p1;
        p3 <= p2;
    end
    assign bus.llr_rd_data_i = rd_data;
    assign bus.facc_bits_i   = p3;

    int rd_addr_q[$], rd_cyc_q[$], fz_q[$], bv_idx_q[$], bv_bits_q[$], bv_cyc_q[$], done_q[$], hs_q[$];
    int llr_bad = 0, bits_idle_bad = 0, frz_bad = 0;
    logic rd_prev = 1'b0;

    always @(negedge clk) begin
        if (bus.llr_rd_en_o) begin
            rd_addr_q.push_back(int'(bus.llr_rd_addr_o));
            rd_cyc_q.push_back(cyc);
        end
        if (rd_prev) fz_q.push_back(int'(bus.facc_frozen_o));
        else if (bus.facc_frozen_o != 4'hF) frz_bad++;
        rd_prev = bus.llr_rd_en_o;
        if (bus.bits_valid_o) begin
            bv_idx_q.push_back(int'(bus.bits_idx_o));
            bv_bits_q.push_back(int'(bus.bits_o));
            bv_cyc_q.push_back(cyc);
        end else if (bus.bits_o != 4'd0) bits_idle_bad++;
        if (bus.done_o) done_q.push_back(cyc);
        if (bus.cmd_valid_i && bus.cmd_ready_o && !rst) hs_q.push_back(cyc);
        if (bus.facc_llr_o !== bus.llr_rd_data_i) llr_bad++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        rd_addr_q.delete(); rd_cyc_q.delete(); fz_q.delete();
        bv_idx_q.delete(); bv_bits_q.delete(); bv_cyc_q.delete();
        done_q.delete(); hs_q.delete();
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.done_o) begin seen = 1'b1; break; end
        end
        check({name, "_done_seen"}, 32'(seen), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic run_job(input string name, input logic [7:0] base, input logic [3:0] num,
                           input logic [31:0] mask);
        bit acc = 1'b0;
        clear_mon();
        @(posedge clk); #1;
        bus.base_addr_i   = base;
        bus.num_chunks_i  = num;
        bus.frozen_mask_i = mask;
        bus.cmd_valid_i   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.cmd_ready_o) begin acc = 1'b1; break; end
        end
        check({name, "_accepted"}, 32'(acc), 32'd1);
        @(posedge clk); #1;
        bus.cmd_valid_i = 1'b0;
        wait_done(name);
    endtask

    // Expected: reads at h+1+k, frozen nibble k, result k at h+6+k, done at h+n+6 (h+1 for n=0).
    task automatic check_job(input string name, input int base, input int n, input logic [31:0] mask);
        int h;
        int a;
        h = (hs_q.size() > 0) ? hs_q[0] : -100;
        check({name, "_n_reads"}, rd_addr_q.size(), n);
        check({name, "_n_results"}, bv_idx_q.size(), n);
        check({name, "_n_done"}, done_q.size(), 1);
        for (int k = 0; k < n && k < rd_addr_q.size() && k < bv_idx_q.size(); k++) begin
            a = (base + k) & 255;
            check($sformatf("%s_addr%0d", name, k), rd_addr_q[k], a);
            check($sformatf("%s_rdcyc%0d", name, k), rd_cyc_q[k], h + 1 + k);
            check($sformatf("%s_frozen%0d", name, k), fz_q[k], (mask >> (4 * k)) & 32'hF);
            check($sformatf("%s_idx%0d", name, k), bv_idx_q[k], k);
            check($sformatf("%s_bits%0d", name, k), bv_bits_q[k], (a ^ 32'hA5) & 32'hF);
            check($sformatf("%s_bvcyc%0d", name, k), bv_cyc_q[k], h + 6 + k);
        end
        if (done_q.size() > 0)
            check({name, "_done_cyc"}, done_q[0], (n == 0) ? h + 1 : h + n + 6);
        $display("job %s base=0x%0h n=%0d handshake_cyc=%0d results=%0d", name, base, n, h, bv_idx_q.size());
    endtask

    initial begin
        int h;
        int bv_before;
        bus.cmd_valid_i   = 1'b0;
        bus.base_addr_i   = '0;
        bus.num_chunks_i  = '0;
        bus.frozen_mask_i = '0;

        // Reset state
        @(posedge clk); #1; rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(bus.cmd_ready_o), 32'd1);
        check("rst_frozen", 32'(bus.facc_frozen_o), 32'hF);
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        check("rst_done", 32'(bus.done_o), 32'd0);
        check("rst_bvalid", 32'(bus.bits_valid_o), 32'd0);
        check("rst_bits", 32'(bus.bits_o), 32'd0);
        check("rst_rden", 32'(bus.llr_rd_en_o), 32'd0);
        @(posedge clk); #1; rst = 1'b0;

        run_job("j4", 8'h10, 4'd4, 32'h0000_4321);
        check_job("j4", 'h10, 4, 32'h0000_4321);
`ifdef FACC_CTRL_PERF_CNT_EN
        check("j4_perf", 32'(perf), 32'd11);
`endif

        run_job("j0", 8'h55, 4'd0, 32'hFFFF_FFFF);
        check_job("j0", 'h55, 0, 32'hFFFF_FFFF);
`ifdef FACC_CTRL_PERF_CNT_EN
        check("j0_perf", 32'(perf), 32'd2);
`endif

        run_job("j12", 8'hFE, 4'd12, 32'h8765_4321);
        check_job("j12", 'hFE, 8, 32'h8765_4321);

        // cmd_valid held high across a job: second accept only in the IDLE cycle after done_o
        clear_mon();
        @(posedge clk); #1;
        bus.base_addr_i = 8'h20; bus.num_chunks_i = 4'd1; bus.frozen_mask_i = 32'h9;
        bus.cmd_valid_i = 1'b1;
        for (int i = 0; i < 40 && hs_q.size() < 2; i++) @(negedge clk);
        @(posedge clk); #1; bus.cmd_valid_i = 1'b0;
        check("hold_n_hs", hs_q.size(), 2);
        if (hs_q.size() >= 2 && done_q.size() >= 1) begin
            check("hold_after_done", hs_q[1], done_q[0] + 1);
            check("hold_gap", hs_q[1], hs_q[0] + 8);
        end
        wait_done("hold2");
        check("hold_n_done", done_q.size(), 2);
        $display("job hold base=0x20 n=1 twice handshakes=%0d", hs_q.size());

        // Reset in DRAIN with idx 2 and 3 still in flight
        clear_mon();
        @(posedge clk); #1;
        bus.base_addr_i = 8'h30; bus.num_chunks_i = 4'd4; bus.frozen_mask_i = 32'h1111;
        bus.cmd_valid_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.cmd_ready_o) break;
        end
        h = cyc;
        @(posedge clk); #1; bus.cmd_valid_i = 1'b0;
        for (int i = 0; i < 30 && cyc < h + 7; i++) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        repeat (15) @(negedge clk);
        check("rstdrain_results", bv_idx_q.size(), 2);
        check("rstdrain_done", done_q.size(), 0);
        check("rstdrain_busy", 32'(bus.busy_o), 32'd0);
        $display("job rstdrain base=0x30 n=4 results_before_reset=%0d", bv_idx_q.size());

        // cmd_valid during reset is not accepted
        clear_mon();
        @(posedge clk); #1;
        rst = 1'b1; bus.num_chunks_i = 4'd3; bus.cmd_valid_i = 1'b1;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0; bus.cmd_valid_i = 1'b0;
        repeat (5) @(negedge clk);
        check("rstvalid_reads", rd_addr_q.size(), 0);
        check("rstvalid_busy", 32'(bus.busy_o), 32'd0);
        $display("job rstvalid n=3 reads=%0d", rd_addr_q.size());

        run_job("j2", 8'h40, 4'd2, 32'h0000_00A5);
        check_job("j2", 'h40, 2, 32'h0000_00A5);

        check("llr_passthrough", llr_bad, 0);
        check("bits_idle_zero", bits_idle_bad, 0);
        check("frozen_idle_ones", frz_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
